// File: rtl/march_sequencer_pkg.sv
// Shared defines and types for the March C- sequencer: address modes, FSM states, element table.
`ifndef MARCH_SEQUENCER_DEFINES
`define MARCH_SEQUENCER_DEFINES
`define ADDR_WIDTH 8
`define ADMD_LIUD 1'b0
`define ADMD_PRUD 1'b1
`endif

package march_sequencer_pkg;

    localparam logic ADMD_LIUD = `ADMD_LIUD;
    localparam logic ADMD_PRUD = `ADMD_PRUD;
    localparam logic [2:0] LAST_ELEM = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic down;
        logic two_ops;
        logic op0_wr;
        logic op0_val;
        logic op1_wr;
        logic op1_val;
    } elem_t;

    // March C-: M0 (w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 (r0)
    function automatic elem_t elem_info(input logic [2:0] idx);
        elem_t e;
        case (idx)
            3'd0:    e = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b1, op0_val: 1'b0, op1_wr: 1'b0, op1_val: 1'b0};
            3'd1:    e = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b0, op1_wr: 1'b1, op1_val: 1'b1};
            3'd2:    e = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b1, op1_wr: 1'b1, op1_val: 1'b0};
            3'd3:    e = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b0, op1_wr: 1'b1, op1_val: 1'b1};
            3'd4:    e = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b1, op1_wr: 1'b1, op1_val: 1'b0};
            3'd5:    e = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b0, op0_val: 1'b0, op1_wr: 1'b0, op1_val: 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/march_comparator.sv
// Read-data checker: registers expected bit and address with each read, compares one cycle later.
// Latency: fail/fail_addr update the edge after the compare cycle. No backpressure; fail is sticky until clear.
module march_comparator #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  rd,
    input  logic                  exp_val,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    logic                  chk;
    logic                  exp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  mism;

    assign mism = chk && (rdata != {DATA_WIDTH{exp_q}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk       <= 1'b0;
            exp_q     <= 1'b0;
            addr_q    <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
        end else if (clear) begin
            chk       <= 1'b0;
            exp_q     <= 1'b0;
            addr_q    <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
        end else begin
            chk    <= rd;
            exp_q  <= exp_val;
            addr_q <= addr;
            // only the first mismatch is recorded
            if (mism && !fail) begin
                fail      <= 1'b1;
                fail_addr <= addr_q;
            end
        end
    end

endmodule

// File: rtl/march_sequencer.sv
// March C- test sequencer driving an external address counter and a memory port.
// Latency: one op per cycle, one LOAD cycle per element, one DRAIN cycle. No backpressure; start ignored while busy.
module march_sequencer
    import march_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  admd_cfg_in,
    input  logic [ADDR_WIDTH-1:0] tas_in,
    input  logic [DATA_WIDTH-1:0] rdata_in,
    output logic                  admd_out,
    output logic                  hold_out,
    output logic                  updwn_out,
    output logic                  s_out,
    output logic                  r_out,
    output logic                  we_out,
    output logic                  re_out,
    output logic [DATA_WIDTH-1:0] wdata_out,
    output logic                  done_out,
    output logic                  fail_out,
    output logic [ADDR_WIDTH-1:0] fail_addr_out
);

    localparam logic [ADDR_WIDTH:0] LAST_LIUD = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] LAST_PRUD = {1'b0, {(ADDR_WIDTH-1){1'b1}}, 1'b0};

    state_t              state, nstate;
    logic [2:0]          elem, nelem;
    logic                op, nop;
    logic [ADDR_WIDTH:0] visit, nvisit;
    logic                nadmd;
    logic                start_go;
    logic                two_ops;
    logic                exp_val;
    elem_t               ninfo;
    logic                nwr, nval, nlast_op, nlast_visit;
    logic                cur_last_op, cur_last_visit;

    assign cur_last_op    = !two_ops || op;
    assign cur_last_visit = visit == ((admd_out == ADMD_PRUD) ? LAST_PRUD : LAST_LIUD);

    always_comb begin
        nstate   = state;
        nelem    = elem;
        nop      = op;
        nvisit   = visit;
        nadmd    = admd_out;
        start_go = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_in) begin
                    nstate   = ST_LOAD;
                    nelem    = '0;
                    nop      = 1'b0;
                    nvisit   = '0;
                    nadmd    = admd_cfg_in;
                    start_go = 1'b1;
                end
            end
            ST_LOAD: nstate = ST_RUN;
            ST_RUN: begin
                if (!cur_last_op) begin
                    nop = 1'b1;
                end else begin
                    nop = 1'b0;
                    if (!cur_last_visit) begin
                        nvisit = visit + 1'b1;
                    end else begin
                        nvisit = '0;
                        if (elem == LAST_ELEM) begin
                            nstate = ST_DRAIN;
                        end else begin
                            nelem  = elem + 3'd1;
                            nstate = ST_LOAD;
                        end
                    end
                end
            end
            ST_DRAIN: nstate = ST_DONE;
            default:  nstate = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered, not combinational.
    assign ninfo       = elem_info(nelem);
    assign nwr         = nop ? ninfo.op1_wr  : ninfo.op0_wr;
    assign nval        = nop ? ninfo.op1_val : ninfo.op0_val;
    assign nlast_op    = !ninfo.two_ops || nop;
    assign nlast_visit = nvisit == ((nadmd == ADMD_PRUD) ? LAST_PRUD : LAST_LIUD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            elem      <= '0;
            op        <= 1'b0;
            visit     <= '0;
            two_ops   <= 1'b0;
            exp_val   <= 1'b0;
            admd_out  <= 1'b0;
            s_out     <= 1'b0;
            r_out     <= 1'b0;
            we_out    <= 1'b0;
            re_out    <= 1'b0;
            wdata_out <= '0;
            hold_out  <= 1'b1;
            updwn_out <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            state     <= nstate;
            elem      <= nelem;
            op        <= nop;
            visit     <= nvisit;
            two_ops   <= ninfo.two_ops;
            exp_val   <= nval;
            admd_out  <= nadmd;
            s_out     <= (nstate == ST_LOAD) && !ninfo.down;
            r_out     <= (nstate == ST_LOAD) && ninfo.down;
            we_out    <= (nstate == ST_RUN) && nwr;
            re_out    <= (nstate == ST_RUN) && !nwr;
            wdata_out <= {DATA_WIDTH{(nstate == ST_RUN) && nwr && nval}};
            hold_out  <= !((nstate == ST_RUN) && nlast_op && !nlast_visit);
            updwn_out <= ((nstate == ST_LOAD) || (nstate == ST_RUN)) && ninfo.down;
            done_out  <= nstate == ST_DONE;
        end
    end

    march_comparator #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_go),
        .rd        (re_out),
        .exp_val   (exp_val),
        .addr      (tas_in),
        .rdata     (rdata_in),
        .fail      (fail_out),
        .fail_addr (fail_addr_out)
    );

endmodule

// File: doc/march_sequencer.md
MARCH_SEQUENCER -- requirements
Module: march_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH, the width of the test address.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the memory data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_in, input, 1, a level that begins a test when sampled high in IDLE or DONE.
REQ-006 SHALL have port admd_cfg_in, input, 1, the address mode (`ADMD_LIUD or `ADMD_PRUD), sampled at start.
REQ-007 SHALL have port tas_in, input, ADDR_WIDTH, the current address from the address counter.
REQ-008 SHALL have port rdata_in, input, DATA_WIDTH, memory read data, valid one cycle after re_out.
REQ-009 SHALL have ports admd_out, hold_out, updwn_out, s_out and r_out, all outputs of width 1, driving the address counter.
REQ-010 SHALL have ports we_out and re_out, outputs of width 1; and wdata_out, output, DATA_WIDTH.
REQ-011 SHALL have ports done_out and fail_out, outputs of width 1; and fail_addr_out, output, ADDR_WIDTH, the first failing address.

Function
REQ-012 SHALL execute March C- as six elements: M0 either(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 either(r0); "either" runs up.
REQ-013 SHALL use FSM states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-014 IDLE/DONE SHALL go to LOAD on start_in=1, latching admd_cfg_in into admd_out, clearing fail_out, fail_addr_out and element/op/visit counters.
REQ-015 LOAD SHALL last exactly one cycle: s_out=1 for an up element, r_out=1 for a down element, then RUN.
REQ-016 RUN SHALL issue one operation per cycle at tas_in: we_out=1 for writes, re_out=1 for reads; wdata_out is all-zeros for op-value 0 and all-ones for op-value 1.
REQ-017 In RUN, hold_out SHALL be 1 except on the final op of a non-final address; on that cycle hold_out=0 and updwn_out is the element direction (0 up, 1 down).
REQ-018 The element address count N SHALL be 2^ADDR_WIDTH for LIUD and 2^ADDR_WIDTH-1 for PRUD, tracked by an internal visit counter (ADDR_WIDTH+1 bits), not by comparing tas_in.
REQ-019 The final op of the final address SHALL go to LOAD with the next element, or to DRAIN after M5.
REQ-020 DRAIN SHALL last one cycle for the last read compare, then DONE; done_out=1 only in DONE.
REQ-021 SHALL register the expected value and tas_in with each read, and compare against rdata_in on the next cycle.
REQ-022 On a mismatch, fail_out SHALL set and stay sticky until the next start; fail_addr_out captures only the first failing address.
REQ-023 start_in SHALL be ignored in LOAD, RUN and DRAIN.
REQ-024 Outside LOAD and RUN, SHALL hold s_out=r_out=we_out=re_out=0 and hold_out=1.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and zero all counters, done_out, fail_out, fail_addr_out, we_out, re_out, s_out, r_out, updwn_out, wdata_out and admd_out, with hold_out=1, including mid-test.
REQ-026 After reset release, SHALL remain in IDLE until start_in is sampled high.

Structure
REQ-027 The March element table (direction, op count, op type and value per op), state encodings and the ADMD constants SHALL live in the shared defines file.
REQ-028 The compare/fail-capture logic SHALL be one sub-module, march_comparator; the sequencer SHALL instantiate it.

Verification
REQ-029 Bench SHALL cover: LIUD, ADDR_WIDTH=8, fault-free memory model -> done_out first high 2568 edges after the start-sampling edge, with fail_out=0.
REQ-030 Bench SHALL cover: PRUD, ADDR_WIDTH=8 -> N=255 per element, done_out after 2558 edges, and every LFSR state visited once per element.
REQ-031 Bench SHALL cover: stuck-at-0 at address 0x2A, LIUD -> fail_out=1 and fail_addr_out=0x2A at the first r1 in M2; it stays 0x2A despite later mismatches.
REQ-032 Bench SHALL cover: s_out/r_out check -> exactly 6 LOAD pulses, with r_out only for M3 and M4.
REQ-033 Bench SHALL cover: rst_n low during M3 -> outputs reach reset values asynchronously, and a new start runs a full clean test.
REQ-034 Bench SHALL cover: start_in held high throughout -> no restart until DONE, then immediately re-enters LOAD with fail_out cleared.
